pc_fetch_unit: RTL and testbench

PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

---
 rtl/pc_pkg.sv | 21 ++
 rtl/next_pc_calc.sv | 42 ++++
 rtl/pc_fetch_unit.sv | 116 +++++++++++
 tb/tb_pc_fetch_unit.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared types and constants for the PC fetch unit: FSM states, next-PC
// select encoding and the sequential increment.
package pc_pkg;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_HALT  = 2'd3
  } pc_state_e;

  typedef enum logic [1:0] {
    SEL_SEQ    = 2'd0,
    SEL_BRANCH = 2'd1,
    SEL_JUMP   = 2'd2,
    SEL_JALR   = 2'd3
  } next_pc_sel_e;

  localparam int unsigned PC_INCR = 4;

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection: JALR > JAL > taken branch > sequential.
// Flags a misaligned target (bit1 set) for the FSM to trap on.
import pc_pkg::*;

module next_pc_calc #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] pc,
  input  logic [DATA_WIDTH-1:0] imm,
  input  logic [DATA_WIDTH-1:0] src_a,
  input  logic                  branch,
  input  logic                  take_branch,
  input  logic                  jump,
  input  logic                  jalr,
  output logic [DATA_WIDTH-1:0] next_pc,
  output next_pc_sel_e          sel,
  output logic                  misalign
);

  logic [DATA_WIDTH-1:0] jalr_sum;

  assign jalr_sum = src_a + imm;

  always_comb begin
    sel = SEL_SEQ;
    if (jalr)                       sel = SEL_JALR;
    else if (jump)                  sel = SEL_JUMP;
    else if (branch && take_branch) sel = SEL_BRANCH;
  end

  always_comb begin
    next_pc = pc + DATA_WIDTH'(PC_INCR);
    unique case (sel)
      SEL_JALR:             next_pc = {jalr_sum[DATA_WIDTH-1:1], 1'b0};
      SEL_JUMP, SEL_BRANCH: next_pc = pc + imm;
      default:              next_pc = pc + DATA_WIDTH'(PC_INCR);
    endcase
  end

  assign misalign = next_pc[1];

endmodule

// File: rtl/pc_fetch_unit.sv
// PC fetch/sequencing FSM with PC register and sticky misalignment trap.
// Optional retired-instruction counter enabled by macro PC_RETIRE_COUNT_EN.
//
// state    | meaning
// BOOT     | one cycle after reset, no request
// FETCH    | IReq high, PC held, waiting for IGnt
// EXEC     | instruction at PC executing; PC updates on exit unless stalled
// HALT     | misaligned target trapped; absorbing until reset
import pc_pkg::*;

module pc_fetch_unit #(
  parameter int                  DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  TakeBranch,
  input  logic                  Branch,
  input  logic                  Jump,
  input  logic                  JalR,
  input  logic [DATA_WIDTH-1:0] Imm,
  input  logic [DATA_WIDTH-1:0] SrcA,
  input  logic                  Stall,
  input  logic                  IGnt,
  output logic                  IReq,
  output logic [DATA_WIDTH-1:0] PC,
  output logic [DATA_WIDTH-1:0] PCPlus4,
  output logic                  InstrValid,
  output logic                  Redirect,
  output logic                  MisalignErr
`ifdef PC_RETIRE_COUNT_EN
  ,
  output logic [DATA_WIDTH-1:0] InstrCount
`endif
);

  pc_state_e             state, state_nxt;
  logic [DATA_WIDTH-1:0] next_pc;
  next_pc_sel_e          sel;
  logic                  misalign;
  logic                  retire;
  logic                  halt_entry;

  next_pc_calc #(.DATA_WIDTH(DATA_WIDTH)) u_next_pc (
    .pc          (PC),
    .imm         (Imm),
    .src_a       (SrcA),
    .branch      (Branch),
    .take_branch (TakeBranch),
    .jump        (Jump),
    .jalr        (JalR),
    .next_pc     (next_pc),
    .sel         (sel),
    .misalign    (misalign)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_BOOT;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_BOOT:  state_nxt = ST_FETCH;
      ST_FETCH: if (IGnt) state_nxt = ST_EXEC;
      ST_EXEC:  if (!Stall) state_nxt = misalign ? ST_HALT : ST_FETCH;
      ST_HALT:  state_nxt = ST_HALT;
      default:  state_nxt = ST_BOOT;
    endcase
  end

  always_comb begin
    IReq       = 1'b0;
    InstrValid = 1'b0;
    Redirect   = 1'b0;
    retire     = 1'b0;
    halt_entry = 1'b0;
    unique case (state)
      ST_FETCH: IReq = 1'b1;
      ST_EXEC: begin
        InstrValid = 1'b1;
        if (!Stall) begin
          // A misaligned target traps without redirecting or retiring
          if (misalign) begin
            halt_entry = 1'b1;
          end else begin
            retire   = 1'b1;
            Redirect = (sel != SEL_SEQ);
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      PC          <= RESET_PC;
      MisalignErr <= 1'b0;
    end else begin
      if (retire)     PC          <= next_pc;
      if (halt_entry) MisalignErr <= 1'b1;
    end
  end

  assign PCPlus4 = PC + DATA_WIDTH'(PC_INCR);

`ifdef PC_RETIRE_COUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      InstrCount <= '0;
    else if (retire) InstrCount <= InstrCount + 1'b1;
  end
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed scenarios plus a randomized
// instruction stream checked against an architectural next-PC model.
module tb_pc_fetch_unit;

  localparam logic [31:0] RPC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        TakeBranch = 1'b0, Branch = 1'b0, Jump = 1'b0, JalR = 1'b0;
  logic [31:0] Imm = '0, SrcA = '0;
  logic        Stall = 1'b0, IGnt = 1'b0;
  logic        IReq, InstrValid, Redirect, MisalignErr;
  logic [31:0] PC, PCPlus4;
`ifdef PC_RETIRE_COUNT_EN
  logic [31:0] InstrCount;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_pc;

  pc_fetch_unit #(.DATA_WIDTH(32), .RESET_PC(RPC)) dut (
    .clk(clk), .rst_n(rst_n), .TakeBranch(TakeBranch), .Branch(Branch),
    .Jump(Jump), .JalR(JalR), .Imm(Imm), .SrcA(SrcA), .Stall(Stall),
    .IGnt(IGnt), .IReq(IReq), .PC(PC), .PCPlus4(PCPlus4),
    .InstrValid(InstrValid), .Redirect(Redirect), .MisalignErr(MisalignErr)
`ifdef PC_RETIRE_COUNT_EN
    , .InstrCount(InstrCount)
`endif
  );

  always #5 clk = ~clk;

  // Architectural next-PC rule set
  function automatic logic [31:0] model_next(input logic [31:0] pc, input logic jr, jp, br, tk,
                                             input logic [31:0] imm, sa);
    if (jr) return (sa + imm) & 32'hFFFF_FFFE;
    if (jp || (br && tk)) return pc + imm;
    return pc + 32'd4;
  endfunction

  function automatic logic model_redir(input logic jr, jp, br, tk);
    return jr || jp || (br && tk);
  endfunction

  // Runs one instruction from FETCH (entered at a negedge) through EXEC exit.
  task automatic do_instr(input logic jr, jp, br, tk, input logic [31:0] imm, sa,
                          input int gw, input int sn, output logic redir,
                          output logic [31:0] pc_a, output logic hold_ok,
                          output logic ireq_a, output logic iv_a);
    logic [31:0] p0;
    p0 = PC;
    hold_ok = 1'b1;
    IGnt = 1'b0;
    repeat (gw) begin
      JalR = 1'($urandom); Jump = 1'($urandom); Branch = 1'($urandom);
      TakeBranch = 1'($urandom); Stall = 1'($urandom); Imm = $urandom;
      #1;
      if (PC !== p0 || IReq !== 1'b1 || Redirect !== 1'b0 || InstrValid !== 1'b0) hold_ok = 1'b0;
      @(negedge clk);
    end
    IGnt = 1'b1;
    #1;
    if (PC !== p0 || IReq !== 1'b1) hold_ok = 1'b0;
    @(negedge clk);
    IGnt = 1'b0;
    JalR = jr; Jump = jp; Branch = br; TakeBranch = tk; Imm = imm; SrcA = sa;
    Stall = (sn > 0);
    repeat (sn) begin
      #1;
      if (InstrValid !== 1'b1 || Redirect !== 1'b0 || PC !== p0) hold_ok = 1'b0;
      @(negedge clk);
    end
    Stall = 1'b0;
    #1;
    redir = Redirect;
    if (InstrValid !== 1'b1) hold_ok = 1'b0;
    @(negedge clk);
    pc_a = PC; ireq_a = IReq; iv_a = InstrValid;
    JalR = 1'b0; Jump = 1'b0; Branch = 1'b0; TakeBranch = 1'b0;
  endtask

  task automatic reset_dut();
    rst_n = 1'b0; IGnt = 1'b0; Stall = 1'b0;
    JalR = 1'b0; Jump = 1'b0; Branch = 1'b0; TakeBranch = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    exp_pc = RPC;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    n_checks++; if (PC !== RPC) begin n_fail++; $display("FAIL reset_pc: got %h want %h", PC, RPC); end
    n_checks++; if (IReq !== 1'b0) begin n_fail++; $display("FAIL reset_ireq: got %b want 0", IReq); end
    n_checks++; if (InstrValid !== 1'b0 || Redirect !== 1'b0 || MisalignErr !== 1'b0) begin
      n_fail++; $display("FAIL reset_flags: got iv=%b rd=%b me=%b want 000", InstrValid, Redirect, MisalignErr); end
    n_checks++; if (PCPlus4 !== RPC + 32'd4) begin n_fail++; $display("FAIL reset_pcplus4: got %h want %h", PCPlus4, RPC + 32'd4); end
`ifdef PC_RETIRE_COUNT_EN
    n_checks++; if (InstrCount !== 32'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", InstrCount); end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++; if (IReq !== 1'b0) begin n_fail++; $display("FAIL boot_cycle_ireq: got %b want 0", IReq); end
    @(negedge clk);
    n_checks++; if (IReq !== 1'b1 || PC !== RPC) begin
      n_fail++; $display("FAIL first_fetch: got ireq=%b pc=%h want 1 %h", IReq, PC, RPC); end
    exp_pc = RPC;
  endtask

  task automatic test_sequential();
    IGnt = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1;
      n_checks++;
      if (PC !== RPC + 32'(4 * (k / 2)) || InstrValid !== 1'(k % 2) || IReq !== 1'(1 - k % 2)) begin
        n_fail++;
        $display("FAIL seq_cycle%0d: got pc=%h iv=%b ireq=%b want pc=%h iv=%0d", k, PC, InstrValid,
                 IReq, RPC + 32'(4 * (k / 2)), k % 2);
      end
      @(negedge clk);
    end
    IGnt = 1'b0;
    exp_pc = RPC + 32'd12;
    n_checks++; if (PC !== exp_pc || IReq !== 1'b1) begin
      n_fail++; $display("FAIL seq_end: got pc=%h ireq=%b want %h 1", PC, IReq, exp_pc); end
  endtask

  task automatic test_branch();
    logic rd, ok, ir, iv;
    logic [31:0] pa;
    do_instr(0, 1, 0, 0, 32'h100 - exp_pc, 0, 0, 0, rd, pa, ok, ir, iv);
    exp_pc = 32'h100;
    n_checks++; if (pa !== exp_pc || rd !== 1'b1) begin
      n_fail++; $display("FAIL jump_to_100: got pc=%h rd=%b want %h 1", pa, rd, exp_pc); end
    do_instr(0, 0, 1, 1, 32'hFFFF_FFF0, 0, 1, 0, rd, pa, ok, ir, iv);
    n_checks++; if (pa !== 32'hF0 || rd !== 1'b1 || ok !== 1'b1) begin
      n_fail++; $display("FAIL branch_taken: got pc=%h rd=%b hold=%b want 000000f0 1 1", pa, rd, ok); end
    do_instr(0, 1, 0, 0, 32'h10, 0, 0, 0, rd, pa, ok, ir, iv);
    do_instr(0, 0, 1, 0, 32'hFFFF_FFF0, 0, 0, 0, rd, pa, ok, ir, iv);
    n_checks++; if (pa !== 32'h104 || rd !== 1'b0) begin
      n_fail++; $display("FAIL branch_not_taken: got pc=%h rd=%b want 00000104 0", pa, rd); end
    do_instr(0, 0, 0, 1, 32'h40, 0, 0, 0, rd, pa, ok, ir, iv);
    exp_pc = 32'h108;
    n_checks++; if (pa !== exp_pc || rd !== 1'b0) begin
      n_fail++; $display("FAIL takebranch_without_branch: got pc=%h rd=%b want %h 0", pa, rd, exp_pc); end
  endtask

  task automatic test_jalr_priority();
    logic rd, ok, ir, iv;
    logic [31:0] pa;
    do_instr(1, 1, 1, 1, 32'h1, 32'h203, 0, 0, rd, pa, ok, ir, iv);
    exp_pc = 32'h204;
    n_checks++; if (pa !== exp_pc || rd !== 1'b1) begin
      n_fail++; $display("FAIL jalr_priority: got pc=%h rd=%b want %h 1", pa, rd, exp_pc); end
    n_checks++; if (PCPlus4 !== exp_pc + 32'd4) begin
      n_fail++; $display("FAIL pcplus4: got %h want %h", PCPlus4, exp_pc + 32'd4); end
    do_instr(0, 1, 0, 0, 32'h4, 0, 0, 0, rd, pa, ok, ir, iv);
    exp_pc = 32'h208;
    n_checks++; if (pa !== exp_pc || rd !== 1'b1) begin
      n_fail++; $display("FAIL jump_to_pc_plus4: got pc=%h rd=%b want %h 1", pa, rd, exp_pc); end
  endtask

  task automatic test_stall_wait();
    logic rd, ok, ir, iv;
    logic [31:0] pa;
`ifdef PC_RETIRE_COUNT_EN
    logic [31:0] c0;
    c0 = InstrCount;
`endif
    do_instr(0, 0, 0, 0, 32'h0, 0, 5, 3, rd, pa, ok, ir, iv);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL stall_hold: got hold_ok=%b want 1", ok); end
    exp_pc = exp_pc + 32'd4;
    n_checks++; if (pa !== exp_pc || rd !== 1'b0 || ir !== 1'b1) begin
      n_fail++; $display("FAIL stall_exit: got pc=%h rd=%b ireq=%b want %h 0 1", pa, rd, ir, exp_pc); end
`ifdef PC_RETIRE_COUNT_EN
    n_checks++; if (InstrCount !== c0 + 32'd1) begin
      n_fail++; $display("FAIL stall_count: got %0d want %0d", InstrCount, c0 + 32'd1); end
`endif
  endtask

  task automatic test_random();
    logic rd, ok, ir, iv, jr, jp, br, tk, exp_rd;
    logic [31:0] pa, imm, sa, nxt;
    int s, errs;
`ifdef PC_RETIRE_COUNT_EN
    logic [31:0] c0;
    c0 = InstrCount;
`endif
    errs = 0;
    for (int i = 0; i < 40; i++) begin
      jr = ($urandom_range(0, 3) == 0); jp = ($urandom_range(0, 3) == 0);
      br = 1'($urandom); tk = 1'($urandom);
      s = int'($urandom_range(0, 63)) - 32;
      imm = 32'(s * 4);
      sa = $urandom & 32'hFFFF_FFFD;
      nxt = model_next(exp_pc, jr, jp, br, tk, imm, sa);
      exp_rd = model_redir(jr, jp, br, tk);
      do_instr(jr, jp, br, tk, imm, sa, $urandom_range(0, 3), $urandom_range(0, 2), rd, pa, ok, ir, iv);
      n_checks++;
      if (pa !== nxt || rd !== exp_rd || ok !== 1'b1 || ir !== 1'b1) begin
        n_fail++; errs++;
        if (errs <= 5) $display("FAIL random_%0d: got pc=%h rd=%b hold=%b ireq=%b want %h %b 1 1",
                                i, pa, rd, ok, ir, nxt, exp_rd);
      end
      exp_pc = nxt;
    end
`ifdef PC_RETIRE_COUNT_EN
    n_checks++; if (InstrCount !== c0 + 32'd40) begin
      n_fail++; $display("FAIL random_count: got %0d want %0d", InstrCount, c0 + 32'd40); end
`endif
  endtask

  task automatic test_misalign();
    logic rd, ok, ir, iv, stuck;
    logic [31:0] pa;
    reset_dut();
    do_instr(0, 1, 0, 0, 32'h10, 0, 0, 0, rd, pa, ok, ir, iv);
    exp_pc = 32'h10;
    do_instr(0, 1, 0, 0, 32'h6, 0, 0, 0, rd, pa, ok, ir, iv);
    n_checks++; if (pa !== exp_pc || rd !== 1'b0 || MisalignErr !== 1'b1) begin
      n_fail++; $display("FAIL misalign_trap: got pc=%h rd=%b err=%b want %h 0 1", pa, rd, MisalignErr, exp_pc); end
    n_checks++; if (ir !== 1'b0 || iv !== 1'b0) begin
      n_fail++; $display("FAIL halt_outputs: got ireq=%b iv=%b want 0 0", ir, iv); end
    stuck = 1'b1;
    IGnt = 1'b1; Jump = 1'b1; Imm = 32'h40;
    repeat (5) begin
      #1;
      if (IReq !== 1'b0 || InstrValid !== 1'b0 || PC !== exp_pc || MisalignErr !== 1'b1) stuck = 1'b0;
      @(negedge clk);
    end
    IGnt = 1'b0; Jump = 1'b0;
    n_checks++; if (stuck !== 1'b1) begin n_fail++; $display("FAIL halt_absorbing: got stuck=%b want 1", stuck); end
  endtask

  task automatic test_wrap_reset();
    logic rd, ok, ir, iv;
    logic [31:0] pa;
    reset_dut();
    n_checks++; if (MisalignErr !== 1'b0) begin n_fail++; $display("FAIL err_cleared: got %b want 0", MisalignErr); end
    do_instr(0, 1, 0, 0, 32'hFFFF_FFFC, 0, 0, 0, rd, pa, ok, ir, iv);
    n_checks++; if (pa !== 32'hFFFF_FFFC || PCPlus4 !== 32'h0) begin
      n_fail++; $display("FAIL top_of_space: got pc=%h pc4=%h want fffffffc 00000000", pa, PCPlus4); end
    do_instr(0, 0, 0, 0, 32'h0, 0, 0, 0, rd, pa, ok, ir, iv);
    n_checks++; if (pa !== 32'h0 || rd !== 1'b0 || MisalignErr !== 1'b0 || ir !== 1'b1) begin
      n_fail++; $display("FAIL wrap: got pc=%h rd=%b err=%b ireq=%b want 00000000 0 0 1", pa, rd, MisalignErr, ir); end
    do_instr(0, 0, 0, 0, 32'h0, 0, 0, 0, rd, pa, ok, ir, iv);
    IGnt = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (PC !== RPC || IReq !== 1'b0) begin
      n_fail++; $display("FAIL async_reset: got pc=%h ireq=%b want %h 0", PC, IReq, RPC); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++; if (IReq !== 1'b0) begin n_fail++; $display("FAIL reboot_cycle: got ireq=%b want 0", IReq); end
    @(negedge clk);
    n_checks++; if (IReq !== 1'b1 || PC !== RPC) begin
      n_fail++; $display("FAIL refetch: got ireq=%b pc=%h want 1 %h", IReq, PC, RPC); end
    IGnt = 1'b0;
  endtask

  initial begin
    exp_pc = RPC;
    test_reset();
    test_sequential();
    test_branch();
    test_jalr_priority();
    test_stall_wait();
    test_random();
    test_misalign();
    test_wrap_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
